place_piece: RTL and testbench
==============================

// Module: place_piece
// PURPOSE
//  Writer counterpart of the rotation/move collision checkers. On start, writes the 4 cells of a
//  tetromino into board RAM: the piece colour to lock it, or zero to erase it.
//  After a lock it rescans the 4 rows the piece can touch and reports which are full.
//  Cell offsets come from the shared lut(block, rotation, coord_x, coord_y).
//  It owns the board RAM port only while busy.
// PARAMETERS
//  BOARD_W    10  cells per row; address = y*BOARD_W + x
//  BOARD_H    24  rows, 0..BOARD_H-1
//  COL_FIRST  1   first playable column (column 0 is wall)
//  COL_LAST   8   last playable column (column 9 is wall)
//  DATA_W     6   cell word width; 0 = empty
// PORTS
//  clk        in   1       system clock, rising edge
//  resetn     in   1       asynchronous, active-low reset
//  start      in   1       one-cycle request; ignored while busy
//  erase      in   1       sampled with start: 1 = write zeros and skip the scan
//  X_anchor   in   5       piece anchor column
//  Y_anchor   in   6       piece anchor row
//  block      in   3       tetromino type (lut input)
//  rotation   in   2       rotation index (lut input)
//  colour     in   DATA_W  value written when erase=0
//  ram_Q      in   DATA_W  RAM read data, valid 1 cycle after ram_addr
//  ram_addr   out  8       registered RAM address
//  ram_data   out  DATA_W  registered RAM write data
//  ram_wren   out  1       registered write enable
//  busy       out  1       high from the cycle after start is accepted until done
//  done       out  1       one-cycle completion pulse
//  full_rows  out  4       bit i = row Y_anchor+i is full; valid from done until next start
// BEHAVIOUR
//  - Reset (async): state IDLE; ram_addr=0, ram_data=0, ram_wren=0, busy=0, done=0, full_rows=0.
//    Reset mid-operation stops any write immediately; partially written cells stay in RAM.
//  - IDLE: on start, latch erase/X/Y/block/rotation/colour, clear full_rows, go to WRITE.
//    Later changes to the inputs are ignored until done.
//  - WRITE, 4 cycles, cell k=0..3 in order:
//    - offset dx=coord_x[2k+1:2k], dy=coord_y[2k+1:2k].
//    - x=X+dx and y=Y+dy, computed 8 bits wide, no wrap.
//    - ram_addr=y*BOARD_W+x; ram_data=erase?0:colour; ram_wren=1.
//    - If y>=BOARD_H or x>=BOARD_W, suppress that write (ram_wren=0) but still spend the cycle.
//  - After WRITE: erase=1 goes to DONE; erase=0 goes to SCAN.
//  - SCAN, rows r=0..3, exactly 9 cycles per row, ram_wren=0:
//    - cycles 0..7 issue address (Y+r)*BOARD_W + COL_FIRST + c;
//    - cycles 1..8 check the returned ram_Q;
//    - full_rows[r]=1 iff all 8 words are nonzero.
//    - Rows with Y+r>=BOARD_H are not read (full_rows[r]=0) and still take 9 cycles.
//  - DONE: done=1 for one cycle, busy=0 in that cycle, return to IDLE.
//    A start in the DONE cycle is ignored.
//  - Latency, counted from the edge that samples start:
//    - ram_wren for cells 0..3 is visible in cycles 1..4;
//    - done is high in cycle 41 (lock) or cycle 5 (erase).
// TESTING
//  1 lock, X=3 Y=5, lut cell offset (1,2), colour=6'h15
//    -> write of 6'h15 at addr 74 in the matching cycle; exactly 4 wren pulses; done at cycle 41.
//  2 preload row 20 cols 1..8 except the piece cells; lock with Y=18 so the piece fills them
//    -> full_rows[2]=1, all other bits 0.
//  3 lock with Y=22 and cells at dy=2,3
//    -> those writes suppressed (wren low, no addr >= 240); full_rows[3:2]=0; done still at cycle 41.
//  4 erase of the same piece -> 4 writes of 0 at the same addresses; done at cycle 5; full_rows=0.
//  5 second start pulsed during SCAN and in the DONE cycle
//    -> ignored: no extra writes, single done.
//  6 resetn low during WRITE cell 2
//    -> wren drops immediately; all outputs at reset values; next start runs a full sequence.

Source files
------------

// File: rtl/place_piece.sv
// Writes or erases the four cells of a tetromino in board RAM and, after a lock, reports which of the four rows it can touch are full.
// Writes appear in cycles 1..4 after start; done arrives in cycle 41 (lock) or 5 (erase). start is ignored while busy.

module tetromino_lut (
   input  logic [2:0] block,
   input  logic [1:0] rotation,
   output logic [7:0] coord_x,
   output logic [7:0] coord_y
);
   function automatic logic [15:0] pk(input int unsigned x0, y0, x1, y1, x2, y2, x3, y3);
      return {2'(x3), 2'(x2), 2'(x1), 2'(x0), 2'(y3), 2'(y2), 2'(y1), 2'(y0)};
   endfunction

   logic [15:0] w_cells;

   // Cells are listed in write order inside a 4x4 box; block 1 (O) and 7 share the default.
   always_comb begin
      w_cells = pk(1, 0, 2, 0, 1, 1, 2, 1);
      case ({block, rotation})
         5'd0:  w_cells = pk(0, 1, 1, 1, 2, 1, 3, 1);
         5'd1:  w_cells = pk(2, 0, 2, 1, 2, 2, 2, 3);
         5'd2:  w_cells = pk(0, 2, 1, 2, 2, 2, 3, 2);
         5'd3:  w_cells = pk(1, 0, 1, 1, 1, 2, 1, 3);
         5'd8:  w_cells = pk(1, 0, 0, 1, 1, 1, 2, 1);
         5'd9:  w_cells = pk(1, 0, 1, 1, 2, 1, 1, 2);
         5'd10: w_cells = pk(0, 1, 1, 1, 2, 1, 1, 2);
         5'd11: w_cells = pk(1, 0, 0, 1, 1, 1, 1, 2);
         5'd12: w_cells = pk(1, 0, 2, 0, 0, 1, 1, 1);
         5'd13: w_cells = pk(1, 0, 1, 1, 2, 1, 2, 2);
         5'd14: w_cells = pk(1, 1, 2, 1, 0, 2, 1, 2);
         5'd15: w_cells = pk(0, 0, 0, 1, 1, 1, 1, 2);
         5'd16: w_cells = pk(0, 0, 1, 0, 1, 1, 2, 1);
         5'd17: w_cells = pk(2, 0, 1, 1, 2, 1, 1, 2);
         5'd18: w_cells = pk(0, 1, 1, 1, 1, 2, 2, 2);
         5'd19: w_cells = pk(1, 0, 0, 1, 1, 1, 0, 2);
         5'd20: w_cells = pk(0, 0, 0, 1, 1, 1, 2, 1);
         5'd21: w_cells = pk(1, 0, 2, 0, 1, 1, 1, 2);
         5'd22: w_cells = pk(0, 1, 1, 1, 2, 1, 2, 2);
         5'd23: w_cells = pk(1, 0, 1, 1, 0, 2, 1, 2);
         5'd24: w_cells = pk(2, 0, 0, 1, 1, 1, 2, 1);
         5'd25: w_cells = pk(1, 0, 1, 1, 1, 2, 2, 2);
         5'd26: w_cells = pk(0, 1, 1, 1, 2, 1, 0, 2);
         5'd27: w_cells = pk(0, 0, 1, 0, 1, 1, 1, 2);
         default: w_cells = pk(1, 0, 2, 0, 1, 1, 2, 1);
      endcase
   end

   assign coord_x = w_cells[15:8];
   assign coord_y = w_cells[7:0];
endmodule

module place_piece #(
   parameter int BOARD_W   = 10,
   parameter int BOARD_H   = 24,
   parameter int COL_FIRST = 1,
   parameter int COL_LAST  = 8,
   parameter int DATA_W    = 6
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              erase,
   input  logic [4:0]        X_anchor,
   input  logic [5:0]        Y_anchor,
   input  logic [2:0]        block,
   input  logic [1:0]        rotation,
   input  logic [DATA_W-1:0] colour,
   input  logic [DATA_W-1:0] ram_Q,
   output logic [7:0]        ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              busy,
   output logic              done,
   output logic [3:0]        full_rows
);
   localparam int         NCOL     = COL_LAST - COL_FIRST + 1;
   localparam logic [3:0] SCAN_END = 4'(NCOL);
   localparam logic [3:0] LAST_COL = 4'(NCOL - 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_FLUSH, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_erase;
   logic [4:0]          r_x;
   logic [5:0]          r_y;
   logic [2:0]          r_block;
   logic [1:0]          r_rot;
   logic [DATA_W-1:0]   r_colour;
   logic [1:0]          r_cell;
   logic [1:0]          r_row;
   logic [3:0]          r_col;
   logic [7:0]          r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_wren;
   logic [3:0]          r_full;
   logic                r_p1_vld, r_p1_first, r_p1_last;
   logic [1:0]          r_p1_row;
   logic                r_p2_vld, r_p2_first, r_p2_last;
   logic [1:0]          r_p2_row;
   logic                r_row_ok;

   logic [7:0]          w_cx, w_cy;
   logic [1:0]          w_dx, w_dy;
   logic [7:0]          w_wx, w_wy, w_waddr;
   logic                w_w_in;
   logic [7:0]          w_sy, w_saddr;
   logic                w_s_in;
   logic                w_accept, w_issue, w_row_ok;
   logic [7:0]          w_addr_nxt;
   logic [DATA_W-1:0]   w_data_nxt;
   logic                w_wren_nxt;

   tetromino_lut u_lut (
      .block    (r_block),
      .rotation (r_rot),
      .coord_x  (w_cx),
      .coord_y  (w_cy)
   );

   assign w_dx    = w_cx[{r_cell, 1'b0} +: 2];
   assign w_dy    = w_cy[{r_cell, 1'b0} +: 2];
   assign w_wx    = {3'b000, r_x} + {6'b0, w_dx};
   assign w_wy    = {2'b00, r_y} + {6'b0, w_dy};
   assign w_waddr = w_wy * 8'(BOARD_W) + w_wx;
   assign w_w_in  = (w_wy < 8'(BOARD_H)) && (w_wx < 8'(BOARD_W));
   assign w_sy    = {2'b00, r_y} + {6'b0, r_row};
   assign w_saddr = w_sy * 8'(BOARD_W) + 8'(COL_FIRST) + {4'b0, r_col};
   assign w_s_in  = w_sy < 8'(BOARD_H);

   // Read data lines up with r_p2 (address registered, then one RAM cycle).
   assign w_row_ok = (r_p2_first | r_row_ok) & (ram_Q != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_addr_nxt  = r_addr;
      w_data_nxt  = '0;
      w_wren_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            w_addr_nxt = w_waddr;
            w_data_nxt = r_erase ? '0 : r_colour;
            w_wren_nxt = w_w_in;
            if (r_cell == 2'd3) w_state_nxt = r_erase ? S_FLUSH : S_SCAN;
         end
         S_SCAN: begin
            if ((r_col < SCAN_END) && w_s_in) begin
               w_issue    = 1'b1;
               w_addr_nxt = w_saddr;
            end
            if ((r_row == 2'd3) && (r_col == SCAN_END)) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_erase    <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_block    <= '0;
         r_rot      <= '0;
         r_colour   <= '0;
         r_cell     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_wren     <= 1'b0;
         r_full     <= '0;
         r_p1_vld   <= 1'b0;
         r_p1_first <= 1'b0;
         r_p1_last  <= 1'b0;
         r_p1_row   <= '0;
         r_p2_vld   <= 1'b0;
         r_p2_first <= 1'b0;
         r_p2_last  <= 1'b0;
         r_p2_row   <= '0;
         r_row_ok   <= 1'b0;
      end else begin
         r_addr <= w_addr_nxt;
         r_data <= w_data_nxt;
         r_wren <= w_wren_nxt;
         if (w_accept) begin
            r_erase  <= erase;
            r_x      <= X_anchor;
            r_y      <= Y_anchor;
            r_block  <= block;
            r_rot    <= rotation;
            r_colour <= colour;
            r_cell   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_full   <= '0;
         end
         if (r_state == S_WRITE) r_cell <= r_cell + 2'd1;
         if (r_state == S_SCAN) begin
            if (r_col == SCAN_END) begin
               r_col <= '0;
               r_row <= r_row + 2'd1;
            end else begin
               r_col <= r_col + 4'd1;
            end
         end
         r_p1_vld   <= w_issue;
         r_p1_first <= (r_col == 4'd0);
         r_p1_last  <= (r_col == LAST_COL);
         r_p1_row   <= r_row;
         r_p2_vld   <= r_p1_vld;
         r_p2_first <= r_p1_first;
         r_p2_last  <= r_p1_last;
         r_p2_row   <= r_p1_row;
         if (r_p2_vld) begin
            r_row_ok <= w_row_ok;
            if (r_p2_last) r_full[r_p2_row] <= w_row_ok;
         end
      end
   end

   assign ram_addr  = r_addr;
   assign ram_data  = r_data;
   assign ram_wren  = r_wren;
   assign busy      = (r_state == S_WRITE) || (r_state == S_SCAN) || (r_state == S_FLUSH);
   assign done      = (r_state == S_DONE);
   assign full_rows = r_full;
endmodule

// File: tb/tb_place_piece.sv
// Directed bench for place_piece with a behavioural board RAM (one-cycle read latency).
module tb_place_piece;
   logic       clk = 1'b0;
   logic       resetn, start, erase;
   logic [4:0] X_anchor;
   logic [5:0] Y_anchor;
   logic [2:0] block;
   logic [1:0] rotation;
   logic [5:0] colour, ram_Q, ram_data;
   logic [7:0] ram_addr;
   logic       ram_wren, busy, done;
   logic [3:0] full_rows;

   logic [5:0] mem [256];

   int n_tests = 0;
   int n_fail  = 0;
   int n_wr, done_cyc, n_done, bad_addr;
   int wr_cyc [8];
   int wr_addr [8];
   int wr_data [8];
   logic       busy_done;
   logic [3:0] fr_done;

   place_piece dut (
      .clk(clk), .resetn(resetn), .start(start), .erase(erase),
      .X_anchor(X_anchor), .Y_anchor(Y_anchor), .block(block), .rotation(rotation),
      .colour(colour), .ram_Q(ram_Q), .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_wren(ram_wren), .busy(busy), .done(done), .full_rows(full_rows)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_Q <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   // Pulses start, then samples every cycle (n = cycles since the sampling edge)
   // until a few cycles past done. Extra start pulses are raised at cycles x1/x2.
   task automatic run_op(input logic e, input logic [4:0] x, input logic [5:0] y,
                         input logic [2:0] b, input logic [1:0] r, input logic [5:0] c,
                         input int x1, input int x2);
      int n;
      n_wr = 0; done_cyc = -1; n_done = 0; bad_addr = 0; busy_done = 1'b1; fr_done = 'x;
      @(negedge clk);
      erase = e; X_anchor = x; Y_anchor = y; block = b; rotation = r; colour = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0; erase = ~e; X_anchor = x + 5'd7; Y_anchor = y + 6'd9; block = b + 3'd3;
      rotation = r + 2'd1; colour = ~c;
      n = 0;
      while (n < 100 && (done_cyc < 0 || n < done_cyc + 4)) begin
         if (ram_wren) begin
            if (n_wr < 8) begin
               wr_cyc[n_wr] = n; wr_addr[n_wr] = int'(ram_addr); wr_data[n_wr] = int'(ram_data);
            end
            n_wr++;
            if (ram_addr >= 8'd240) bad_addr++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = n; busy_done = busy; fr_done = full_rows;
            end
         end
         start = (n == x1 || n == x2);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
   endtask

   initial begin
      int exp_a [4];
      resetn = 1'b0; start = 1'b0; erase = 1'b0; X_anchor = '0; Y_anchor = '0;
      block = '0; rotation = '0; colour = '0;
      clear_mem();
      #12;
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_full", full_rows, 0);
      @(negedge clk); resetn = 1'b1;

      // 1: T piece rot1 at (3,5): cells (4,5) (4,6) (5,6) (4,7)
      exp_a = '{54, 64, 65, 74};
      run_op(1'b0, 5'd3, 6'd5, 3'd2, 2'd1, 6'h15, -1, -1);
      chk("t1_nwr", n_wr, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t1_cyc%0d", k), wr_cyc[k], k + 1);
         chk($sformatf("t1_addr%0d", k), wr_addr[k], exp_a[k]);
         chk($sformatf("t1_data%0d", k), wr_data[k], 'h15);
      end
      chk("t1_done_cyc", done_cyc, 41);
      chk("t1_ndone", n_done, 1);
      chk("t1_busy_at_done", busy_done, 0);
      chk("t1_full", fr_done, 4'b0000);
      chk("t1_mem74", mem[74], 'h15);

      // 2: I piece flat in row 20 completes it; row 19 misses col 8, row 18 misses col 1
      clear_mem();
      for (int i = 205; i <= 208; i++) mem[i] = 6'h3;
      for (int i = 190; i <= 197; i++) mem[i] = 6'h1;
      mem[199] = 6'h1;
      for (int i = 182; i <= 189; i++) mem[i] = 6'h1;
      run_op(1'b0, 5'd1, 6'd18, 3'd0, 2'd2, 6'h2A, -1, -1);
      chk("t2_nwr", n_wr, 4);
      chk("t2_addr0", wr_addr[0], 201);
      chk("t2_addr3", wr_addr[3], 204);
      chk("t2_done_cyc", done_cyc, 41);
      chk("t2_full", fr_done, 4'b0100);

      // 3: vertical I at Y=22 hangs off the bottom; row 23 gets completed
      clear_mem();
      for (int i = 231; i <= 238; i++) if (i != 235) mem[i] = 6'h7;
      for (int i = 240; i <= 255; i++) mem[i] = 6'h7;
      for (int i = 221; i <= 224; i++) mem[i] = 6'h7;
      run_op(1'b0, 5'd3, 6'd22, 3'd0, 2'd1, 6'h09, -1, -1);
      chk("t3_nwr", n_wr, 2);
      chk("t3_addr0", wr_addr[0], 225);
      chk("t3_addr1", wr_addr[1], 235);
      chk("t3_cyc1", wr_cyc[1], 2);
      chk("t3_bad_addr", bad_addr, 0);
      chk("t3_done_cyc", done_cyc, 41);
      chk("t3_full", fr_done, 4'b0010);

      // 4: erase the piece from test 1
      foreach (exp_a[k]) mem[exp_a[k]] = 6'h15;
      run_op(1'b1, 5'd3, 6'd5, 3'd2, 2'd1, 6'h15, -1, -1);
      chk("t4_nwr", n_wr, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4_addr%0d", k), wr_addr[k], exp_a[k]);
         chk($sformatf("t4_data%0d", k), wr_data[k], 0);
      end
      chk("t4_done_cyc", done_cyc, 5);
      chk("t4_full", fr_done, 4'b0000);
      chk("t4_mem74", mem[74], 0);

      // 5: extra starts during SCAN and in the DONE cycle are ignored
      run_op(1'b0, 5'd4, 6'd10, 3'd1, 2'd0, 6'h0C, 20, 41);
      chk("t5_nwr", n_wr, 4);
      chk("t5_addr0", wr_addr[0], 105);
      chk("t5_addr3", wr_addr[3], 116);
      chk("t5_done_cyc", done_cyc, 41);
      chk("t5_ndone", n_done, 1);
      chk("t5_busy_after", busy, 0);

      // 6: reset during the cell-2 write, then a clean full sequence
      @(negedge clk);
      erase = 1'b0; X_anchor = 5'd2; Y_anchor = 6'd3; block = 3'd2; rotation = 2'd0;
      colour = 6'h11; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_wren_c2", ram_wren, 1);
      chk("t6_addr_c2", ram_addr, 43);
      resetn = 1'b0;
      #1;
      chk("t6_rst_wren", ram_wren, 0);
      chk("t6_rst_addr", ram_addr, 0);
      chk("t6_rst_data", ram_data, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_full", full_rows, 0);
      @(negedge clk); resetn = 1'b1;
      run_op(1'b0, 5'd2, 6'd3, 3'd2, 2'd0, 6'h11, -1, -1);
      chk("t6_nwr", n_wr, 4);
      chk("t6_addr0", wr_addr[0], 33);
      chk("t6_addr3", wr_addr[3], 44);
      chk("t6_done_cyc", done_cyc, 41);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
